timebase_counter: RTL and testbench

Parametrised free-running timebase for the game logic: a WIDTH-bit up/down counter with programmable wrap limit, synchronous clear/load, a terminal-count pulse and NUM_TAPS single-cycle tick strobes derived from selected count bits. Ball, paddle and display-refresh logic consume the `tick` strobes as clock enables on the single system clock. No count bit is used as a derived clock.

---
 rtl/timebase_counter_pkg.sv | 15 +
 rtl/timebase_counter_if.sv | 31 +++
 rtl/timebase_counter_edge_pulse.sv | 30 +++
 rtl/timebase_counter.sv | 99 +++++++++
 tb/tb_timebase_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/timebase_counter_pkg.sv
// Shared constants and parameter-legality check for the timebase counter.
package timebase_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_WIDTH    = 24;
    localparam int DEF_NUM_TAPS = 4;
    localparam int DEF_TAP_LSB  = 16;

    function automatic bit params_legal(input int width, input int num_taps, input int tap_lsb);
        return (width >= 2) && (num_taps >= 1) && (tap_lsb >= 0) && (tap_lsb + num_taps <= width);
    endfunction

endpackage

// File: rtl/timebase_counter_if.sv
// Control/status bundle of the timebase counter; master = consumer, slave = counter.
// TIMEBASE_ONESHOT_EN adds the one_shot control.
interface timebase_counter_if
    import timebase_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_TAPS = DEF_NUM_TAPS
);
    logic                enable;
    logic                clear;
    logic                load;
    logic [WIDTH-1:0]    load_value;
    logic                down;
    logic [WIDTH-1:0]    limit;
    logic [WIDTH-1:0]    out;
    logic                wrap;
    logic [NUM_TAPS-1:0] tick;
`ifdef TIMEBASE_ONESHOT_EN
    logic                one_shot;

    modport master (output enable, clear, load, load_value, down, limit, one_shot,
                    input  out, wrap, tick);
    modport slave  (input  enable, clear, load, load_value, down, limit, one_shot,
                    output out, wrap, tick);
`else
    modport master (output enable, clear, load, load_value, down, limit,
                    input  out, wrap, tick);
    modport slave  (input  enable, clear, load, load_value, down, limit,
                    output out, wrap, tick);
`endif
endinterface

// File: rtl/timebase_counter_edge_pulse.sv
// One-bit rising-edge detector with synchronous clear; i_arm gates whether a
// rise may produce a pulse (history still follows i_sample when disarmed).
module edge_pulse (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_arm,
    input  logic i_sample,
    output logic o_pulse
);
    logic r_hist;
    logic r_pulse;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
        end else if (i_clear) begin
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_hist  <= i_sample;
            r_pulse <= i_arm & i_sample & ~r_hist;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/timebase_counter.sv
// Up/down timebase with wrap limit, clear/load, terminal-count pulse and tick strobes.
// TIMEBASE_ONESHOT_EN: counter stops at its terminal value while one_shot is high.
module timebase_counter
    import timebase_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int TAP_LSB  = DEF_TAP_LSB
) (
    input  logic               clock,
    input  logic               reset_n,
    timebase_counter_if.slave  bus
);
    generate
        if (!params_legal(WIDTH, NUM_TAPS, TAP_LSB)) begin : g_param_check
            $error("timebase_counter: illegal WIDTH/NUM_TAPS/TAP_LSB combination");
        end
    endgenerate

    logic [WIDTH-1:0]    r_out;
    logic                r_wrap;
    logic [WIDTH-1:0]    w_next_out;
    logic                w_next_wrap;
    logic                w_step;
    logic                w_one_shot;
    logic [WIDTH-1:0]    w_inc;
    logic [WIDTH-1:0]    w_dec;
    logic [NUM_TAPS-1:0] w_tick;

`ifdef TIMEBASE_ONESHOT_EN
    assign w_one_shot = bus.one_shot;
`else
    assign w_one_shot = 1'b0;
`endif

    assign w_inc = r_out + 1'b1;
    assign w_dec = r_out - 1'b1;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_out  = r_out;
        w_next_wrap = 1'b0;
        w_step      = 1'b0;
        if (bus.clear) begin
            w_next_out = '0;
        end else if (bus.load) begin
            w_next_out = bus.load_value;
        end else if (bus.enable) begin
            w_step = 1'b1;
            if (bus.down == DIR_UP) begin
                if (r_out < bus.limit) begin
                    w_next_out  = w_inc;
                    w_next_wrap = w_one_shot && (w_inc == bus.limit);
                end else if (!w_one_shot) begin
                    // Values above limit (after load or limit change) also roll to 0.
                    w_next_out  = '0;
                    w_next_wrap = 1'b1;
                end
            end else begin
                if (r_out != '0) begin
                    w_next_out  = w_dec;
                    w_next_wrap = w_one_shot && (w_dec == '0);
                end else if (!w_one_shot) begin
                    w_next_out  = bus.limit;
                    w_next_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_next_out;
            r_wrap <= w_next_wrap;
        end
    end

    // Ticks see the next count so each strobe lines up with the first cycle the bit reads 1.
    generate
        for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
            edge_pulse u_edge (
                .clock    (clock),
                .reset_n  (reset_n),
                .i_clear  (bus.clear),
                .i_arm    (w_step),
                .i_sample (w_next_out[TAP_LSB+i]),
                .o_pulse  (w_tick[i])
            );
        end
    endgenerate

    assign bus.out  = r_out;
    assign bus.wrap = r_wrap;
    assign bus.tick = w_tick;

endmodule

// File: tb/tb_timebase_counter.sv
// Self-checking bench for timebase_counter (WIDTH=8, NUM_TAPS=2, TAP_LSB=2):
// a behavioural model checked every cycle plus directed literal expectations.
module tb_timebase_counter;
    localparam int W  = 8;
    localparam int NT = 2;
    localparam int TL = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    timebase_counter_if #(.WIDTH(W), .NUM_TAPS(NT)) bus ();

    timebase_counter #(.WIDTH(W), .NUM_TAPS(NT), .TAP_LSB(TL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0]   o;
        logic          w;
        logic [NT-1:0] t;
    } mstate_t;

    mstate_t m = '0;

    // Next observable state from the behavioural rules, using whole-number arithmetic.
    function automatic mstate_t model_next(input mstate_t cur);
        mstate_t     n;
        int unsigned lim;
        bit          moved;
        bit          os;
        n     = cur;
        n.w   = 1'b0;
        n.t   = '0;
        lim   = 32'(bus.limit);
        moved = 1'b0;
        os    = 1'b0;
`ifdef TIMEBASE_ONESHOT_EN
        os = bus.one_shot;
`endif
        if (bus.clear) begin
            n.o = 0;
        end else if (bus.load) begin
            n.o = 32'(bus.load_value);
        end else if (bus.enable) begin
            moved = 1'b1;
            if (!bus.down) begin
                if (cur.o < lim) begin
                    n.o = cur.o + 1;
                    n.w = os && (n.o == lim);
                end else if (!os) begin
                    n.o = 0;
                    n.w = 1'b1;
                end
            end else begin
                if (cur.o != 0) begin
                    n.o = cur.o - 1;
                    n.w = os && (n.o == 0);
                end else if (!os) begin
                    n.o = lim;
                    n.w = 1'b1;
                end
            end
        end
        for (int i = 0; i < NT; i++)
            n.t[i] = moved && (((n.o >> (TL + i)) & 1) == 1) && (((cur.o >> (TL + i)) & 1) == 0);
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_next(m);
    end

    always @(negedge clock) begin
        check("model_out",  32'(bus.out),  m.o);
        check("model_wrap", 32'(bus.wrap), 32'(m.w));
        check("model_tick", 32'(bus.tick), 32'(m.t));
    end

    task automatic expect_now(input string name, input int o, input int w, input int t);
        check({name, "_out"},  32'(bus.out),  o);
        check({name, "_wrap"}, 32'(bus.wrap), w);
        check({name, "_tick"}, 32'(bus.tick), t);
    endtask

    task automatic cycle();
        @(negedge clock);
    endtask

    int dn_seq [6] = '{3, 2, 1, 0, 3, 2};
    int v;

    initial begin
        bus.enable     = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.down       = 1'b0;
        bus.limit      = 8'd9;
`ifdef TIMEBASE_ONESHOT_EN
        bus.one_shot   = 1'b0;
`endif
        repeat (2) cycle();
        expect_now("reset", 0, 0, 0);

        // limit 9, up: period 10, tick0 at 4, tick1 at 8
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            v = k % 10;
            expect_now("up9", v, (v == 0) ? 1 : 0, (v == 4) ? 1 : ((v == 8) ? 2 : 0));
        end

        // asynchronous reset at out = 5, then resume 1, 2
        #2 reset_n = 1'b0;
        #1 expect_now("rst_async", 0, 0, 0);
        cycle();
        reset_n = 1'b1;
        cycle(); expect_now("rst_resume1", 1, 0, 0);
        cycle(); expect_now("rst_resume2", 2, 0, 0);

        bus.enable = 1'b0;
        cycle(); expect_now("hold", 2, 0, 0);
        cycle(); expect_now("hold2", 2, 0, 0);

        // down, limit 3, from 0
        bus.clear = 1'b1;
        cycle(); expect_now("clear", 0, 0, 0);
        bus.clear  = 1'b0;
        bus.down   = 1'b1;
        bus.limit  = 8'd3;
        bus.enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            expect_now("down3", dn_seq[k], (dn_seq[k] == 3) ? 1 : 0, 0);
        end

        // load above limit, then clear+load together
        bus.down       = 1'b0;
        bus.limit      = 8'd9;
        bus.load       = 1'b1;
        bus.load_value = 8'd200;
        cycle(); expect_now("load200", 200, 0, 0);
        bus.load = 1'b0;
        cycle(); expect_now("load_wrap", 0, 1, 0);
        bus.load  = 1'b1;
        bus.clear = 1'b1;
        cycle(); expect_now("clr_ld", 0, 0, 0);
        bus.clear      = 1'b0;
        bus.load_value = 8'd4;
        cycle(); expect_now("load4_notick", 4, 0, 0);
        bus.load = 1'b0;
        cycle(); expect_now("after_load4", 5, 0, 0);

        // free run over the full range
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        bus.limit = 8'd255;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            v = k % 256;
            expect_now("free", v, (v == 0) ? 1 : 0,
                       ((v % 8) == 4) ? 1 : (((v % 16) == 8) ? 2 : 0));
        end

        // limit 0: stays 0, wraps every enabled cycle
        bus.limit = 8'd0;
        for (int k = 0; k < 3; k++) begin
            cycle(); expect_now("lim0", 0, 1, 0);
        end

        // limit lowered below count
        bus.limit      = 8'd20;
        bus.load       = 1'b1;
        bus.load_value = 8'd50;
        cycle();
        bus.load = 1'b0;
        cycle(); expect_now("above_limit", 0, 1, 0);

        // direction changes mid-count across the full range (model-checked)
        bus.limit = 8'd255;
        repeat (20) cycle();
        bus.down = 1'b1;
        repeat (40) cycle();
        bus.down = 1'b0;
        repeat (5) cycle();

`ifdef TIMEBASE_ONESHOT_EN
        bus.clear = 1'b1;
        cycle();
        bus.clear    = 1'b0;
        bus.one_shot = 1'b1;
        bus.limit    = 8'd4;
        cycle(); expect_now("os1", 1, 0, 0);
        cycle(); expect_now("os2", 2, 0, 0);
        cycle(); expect_now("os3", 3, 0, 0);
        cycle(); expect_now("os4", 4, 1, 1);
        cycle(); expect_now("os_hold", 4, 0, 0);
        cycle(); expect_now("os_hold2", 4, 0, 0);
        bus.load       = 1'b1;
        bus.load_value = 8'd0;
        cycle(); expect_now("os_rearm", 0, 0, 0);
        bus.load = 1'b0;
        cycle(); expect_now("os_again", 1, 0, 0);
        bus.one_shot = 1'b0;
        cycle();
`endif

        @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
